// File: rtl/dm_pkg.sv
// dm_pkg: shared size encodings, FSM state type and defaults for the byte-lane data memory
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LATENCY_DEF = 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // A request is rejected when its size is reserved or the address is not naturally aligned
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return size == SZ_WORD ? lane != 2'b00 :
               size == SZ_HALF ? lane[0] :
               size != SZ_BYTE;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: picks the addressed byte/half/word out of a memory word and extends it
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = lane == 2'd0 ? word[7:0]   :
               lane == 2'd1 ? word[15:8]  :
               lane == 2'd2 ? word[23:16] : word[31:24];
    assign h = lane[1] ? word[31:16] : word[15:0];

    // Word loads pass straight through; sub-word loads are extended by sign_ext
    always_comb begin
        data = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
               size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : word;
    end

endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: word-organised data memory with byte/half/word stores and extended loads
module dm_bytelane
    import dm_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = LATENCY_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] data_write,
    output logic              ready,
    output logic [DATA_W-1:0] data_read,
    output logic              rd_valid,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx;
    logic              req, bad, ld, st, rj, done;
    logic              fire_v, fire_e;
    logic [3:0]        be;
    logic [DATA_W-1:0] wd, ld_data, pend_data, next_dr;
    logic              pend_err;
    logic              unused_addr;

    assign idx         = address[IDX_W+1:2];
    assign unused_addr = ^address[ADDR_W-1:IDX_W+2];

    assign ready = state == IDLE;
    assign req   = ready && (mem_read || mem_write);
    assign bad   = misaligned(size, address[1:0]);
    assign st    = req && mem_write && !bad;
    assign ld    = req && !mem_write && mem_read && !bad;
    assign rj    = req && bad;
    assign done  = state == BUSY && cnt == CNT_W'(1);

    assign be = size == SZ_BYTE ? 4'b0001 << address[1:0] :
                size == SZ_HALF ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd = size == SZ_BYTE ? {4{data_write[7:0]}} :
                size == SZ_HALF ? {2{data_write[15:0]}} : data_write;

    // With single-cycle latency the result leaves straight from acceptance, else from the pending slot
    assign fire_v  = LATENCY == 1 ? ld : done && !pend_err;
    assign fire_e  = LATENCY == 1 ? rj : done && pend_err;
    assign next_dr = LATENCY == 1 ? ld_data : pend_data;

    dm_lane_align u_align (
        .word     (mem[idx]),
        .size     (size),
        .lane     (address[1:0]),
        .sign_ext (sign_ext),
        .data     (ld_data)
    );

    // Store commits only the enabled byte lanes; memory is never cleared by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (st && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    // Loads and rejects capture their outcome at acceptance so later stores cannot disturb it
    always_ff @(posedge clk) begin
        if (ld || rj) begin
            pend_data <= ld_data;
            pend_err  <= rj;
        end
    end

    // State and latency down-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: loads and rejects stall in BUSY for LATENCY-1 cycles; stores never leave IDLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if ((ld || rj) && LATENCY > 1) begin
                state_n = BUSY;
                cnt_n   = CNT_W'(LATENCY - 1);
            end
        end else begin
            cnt_n = cnt - 1'b1;
            if (done) state_n = IDLE;
        end
    end

    // Result register and one-cycle valid/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            data_read <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid <= fire_v;
            err      <= fire_e;
            if (fire_v) data_read <= next_dr;
        end
    end

endmodule
